// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling and a first-word-fall-through receive FIFO.
// Framing errors and overruns are reported as registered single-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 1250,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic                          i_UART_TXD,
    output logic [7:0]                    o_RX_DATA,
    output logic                          o_RX_VALID,
    input  logic                          i_RX_READY,
    output logic [$clog2(FIFO_DEPTH):0]   o_RX_LEVEL,
    output logic                          o_FRAME_ERR,
    output logic                          o_OVERRUN
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [TW-1:0] HalfLast = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FullLast = TW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] DepthLvl = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;

    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;

    // Receive FSM and bit timer
    always_comb begin
        sync1_d     = i_UART_TXD;
        rx_s_d      = sync1_q;
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    timer_d = '0;
                end
            end
            StStart: begin
                if (timer_q == HalfLast) begin
                    timer_d = '0;
                    if (!rx_s_q) begin
                        state_d = StData;
                        idx_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StData: begin
                if (timer_q == FullLast) begin
                    timer_d         = '0;
                    shift_d[idx_q]  = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StStop: begin
                if (timer_q == FullLast) begin
                    timer_d = '0;
                    state_d = StIdle;
                    if (rx_s_q) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        pop       = (count_q != '0) && i_RX_READY;
        full      = (count_q == DepthLvl);
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + LW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - LW'(1);
        end
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            timer_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign o_RX_DATA   = mem_q[rd_ptr_q];
    assign o_RX_VALID  = (count_q != '0);
    assign o_RX_LEVEL  = count_q;
    assign o_FRAME_ERR = frame_err_q;
    assign o_OVERRUN   = overrun_q;

endmodule
